// File: rtl/irq_pkg.sv
// Shared definitions for the interrupt controller: source IDs, the idle ID
// and the arbitration FSM state encoding.
package irq_pkg;

    typedef logic [2:0] irq_id_t;

    localparam irq_id_t IRQ_UART  = 3'd0;
    localparam irq_id_t IRQ_TIMER = 3'd1;
    localparam irq_id_t IRQ_MEAS  = 3'd2;
    localparam irq_id_t IRQ_GPIO  = 3'd3;
    localparam irq_id_t NO_IRQ    = 3'd7;

    typedef enum logic [1:0] {
        IDLE,
        ASSERT,
        HOLDOFF
    } irq_state_e;

endpackage

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder: the lowest set index of req_i wins.
module irq_prio_enc
    import irq_pkg::*;
#(
    parameter int unsigned NUM_IRQS = 4
) (
    input  logic [NUM_IRQS-1:0] req_i,
    output logic                valid_o,
    output irq_id_t             id_o
);

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        valid_o = |req_i;
        id_o    = NO_IRQ;
        // Scan downward so the last hit, the lowest index, is the one kept.
        for (int i = int'(NUM_IRQS) - 1; i >= 0; i--) begin
            if (req_i[i]) id_o = irq_id_t'(i);
        end
    end

endmodule

// File: rtl/irq_ctrl.sv
// Interrupt controller: edge/level capture into pending bits, masking,
// fixed-priority arbitration and an ack/withdraw/holdoff handshake.
module irq_ctrl
    import irq_pkg::*;
#(
    parameter int unsigned NUM_IRQS = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_IRQS-1:0] irq_sources,
    input  logic [NUM_IRQS-1:0] irq_mask,
    input  logic [NUM_IRQS-1:0] irq_mode,
    input  logic [NUM_IRQS-1:0] pend_clr,
    input  logic                irq_ack,
    output logic [NUM_IRQS-1:0] irq_pending,
    output logic                irq_out,
    output irq_id_t             active_id
);

    logic [NUM_IRQS-1:0] src_q;
    logic [NUM_IRQS-1:0] mask_q;
    logic [NUM_IRQS-1:0] pend_q, pend_d;
    logic [NUM_IRQS-1:0] rise;
    logic [NUM_IRQS-1:0] req;
    logic [NUM_IRQS-1:0] ack_hit;
    logic                req_active;
    logic                enc_valid;
    irq_id_t             enc_id;
    irq_state_e          state_q;
    irq_id_t             active_id_q;
    logic                irq_out_q;

    // Mask is registered so a mask change reaches req one cycle later.
    assign req = pend_q & mask_q;

    always_comb begin
        rise       = irq_sources & ~src_q;
        ack_hit    = '0;
        req_active = 1'b0;
        for (int i = 0; i < int'(NUM_IRQS); i++) begin
            if (active_id_q == irq_id_t'(i)) begin
                ack_hit[i] = irq_ack && (state_q == ASSERT);
                req_active = req[i];
            end
        end
        for (int i = 0; i < int'(NUM_IRQS); i++) begin
            // Edge mode: a new edge beats any clear arriving in the same cycle.
            pend_d[i] = irq_mode[i] ? (rise[i] | (pend_q[i] & ~(pend_clr[i] | ack_hit[i])))
                                    : irq_sources[i];
        end
    end

    irq_prio_enc #(
        .NUM_IRQS (NUM_IRQS)
    ) u_prio_enc (
        .req_i   (req),
        .valid_o (enc_valid),
        .id_o    (enc_id)
    );

    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            src_q       <= '0;
            mask_q      <= '0;
            pend_q      <= '0;
            state_q     <= IDLE;
            active_id_q <= NO_IRQ;
            irq_out_q   <= 1'b0;
        end else begin
            src_q  <= irq_sources;
            mask_q <= irq_mask;
            pend_q <= pend_d;
            case (state_q)
                IDLE: begin
                    if (enc_valid) begin
                        state_q     <= ASSERT;
                        active_id_q <= enc_id;
                        irq_out_q   <= 1'b1;
                    end
                end
                ASSERT: begin
                    // Ack has priority over a simultaneous withdraw.
                    if (irq_ack || !req_active) begin
                        state_q     <= irq_ack ? HOLDOFF : IDLE;
                        active_id_q <= NO_IRQ;
                        irq_out_q   <= 1'b0;
                    end
                end
                HOLDOFF: state_q <= IDLE;
                default: begin
                    state_q     <= IDLE;
                    active_id_q <= NO_IRQ;
                    irq_out_q   <= 1'b0;
                end
            endcase
        end
    end

    assign irq_pending = pend_q;
    assign irq_out     = irq_out_q;
    assign active_id   = active_id_q;

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed bench for irq_ctrl: one task per scenario with hand-computed expectations.
module tb_irq_ctrl;
    import irq_pkg::*;

    logic       clk;
    logic       rst;
    logic [3:0] irq_sources;
    logic [3:0] irq_mask;
    logic [3:0] irq_mode;
    logic [3:0] pend_clr;
    logic       irq_ack;
    logic [3:0] irq_pending;
    logic       irq_out;
    irq_id_t    active_id;

    int vectors;
    int miscompares;

    irq_ctrl #(
        .NUM_IRQS (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .irq_sources (irq_sources),
        .irq_mask    (irq_mask),
        .irq_mode    (irq_mode),
        .pend_clr    (pend_clr),
        .irq_ack     (irq_ack),
        .irq_pending (irq_pending),
        .irq_out     (irq_out),
        .active_id   (active_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle away from it before driving or sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; irq_sources = '0; irq_mask = '0; irq_mode = 4'b1111;
        pend_clr = '0; irq_ack = 1'b0;
        tick(); tick();
        vectors++; if (irq_out !== 1'b0) begin miscompares++; $display("FAIL reset_out got %b want 0", irq_out); end
        vectors++; if (active_id !== 3'd7) begin miscompares++; $display("FAIL reset_id got %0d want 7", active_id); end
        vectors++; if (irq_pending !== 4'b0000) begin miscompares++; $display("FAIL reset_pend got %b want 0000", irq_pending); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_edge_basic();
        irq_mask = 4'b0100; irq_sources = 4'b0100;
        tick();
        vectors++; if (irq_pending !== 4'b0100) begin miscompares++; $display("FAIL edge_pend got %b want 0100", irq_pending); end
        vectors++; if (irq_out !== 1'b0) begin miscompares++; $display("FAIL edge_out_early got %b want 0", irq_out); end
        tick();
        vectors++; if (irq_out !== 1'b1) begin miscompares++; $display("FAIL edge_out got %b want 1", irq_out); end
        vectors++; if (active_id !== 3'd2) begin miscompares++; $display("FAIL edge_id got %0d want 2", active_id); end
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
        vectors++; if (irq_out !== 1'b0) begin miscompares++; $display("FAIL edge_ack_out got %b want 0", irq_out); end
        vectors++; if (active_id !== 3'd7) begin miscompares++; $display("FAIL edge_ack_id got %0d want 7", active_id); end
        vectors++; if (irq_pending !== 4'b0000) begin miscompares++; $display("FAIL edge_ack_pend got %b want 0000", irq_pending); end
        tick(); tick();
        vectors++; if (irq_out !== 1'b0) begin miscompares++; $display("FAIL edge_no_reassert got %b want 0", irq_out); end
        irq_sources = '0;
        tick();
    endtask

    task automatic test_priority();
        irq_mask = 4'b0000;
        irq_sources = 4'b1000; tick();
        irq_sources = 4'b1001; tick();
        vectors++; if (irq_pending !== 4'b1001) begin miscompares++; $display("FAIL prio_pend got %b want 1001", irq_pending); end
        irq_mask = 4'b1111; tick(); tick();
        vectors++; if (irq_out !== 1'b1 || active_id !== 3'd0) begin miscompares++; $display("FAIL prio_first got out=%b id=%0d want out=1 id=0", irq_out, active_id); end
        irq_ack = 1'b1; tick(); irq_ack = 1'b0;
        vectors++; if (irq_out !== 1'b0 || irq_pending !== 4'b1000) begin miscompares++; $display("FAIL prio_ack0 got out=%b pend=%b want out=0 pend=1000", irq_out, irq_pending); end
        tick();
        vectors++; if (irq_out !== 1'b0) begin miscompares++; $display("FAIL prio_holdoff got %b want 0", irq_out); end
        tick();
        vectors++; if (irq_out !== 1'b1 || active_id !== 3'd3) begin miscompares++; $display("FAIL prio_second got out=%b id=%0d want out=1 id=3", irq_out, active_id); end
        irq_sources = 4'b1011; tick();
        vectors++; if (irq_pending !== 4'b1010 || active_id !== 3'd3) begin miscompares++; $display("FAIL prio_nopreempt1 got pend=%b id=%0d want pend=1010 id=3", irq_pending, active_id); end
        tick();
        vectors++; if (irq_out !== 1'b1 || active_id !== 3'd3) begin miscompares++; $display("FAIL prio_nopreempt2 got out=%b id=%0d want out=1 id=3", irq_out, active_id); end
        irq_ack = 1'b1; tick(); irq_ack = 1'b0;
        tick(); tick();
        vectors++; if (irq_out !== 1'b1 || active_id !== 3'd1) begin miscompares++; $display("FAIL prio_third got out=%b id=%0d want out=1 id=1", irq_out, active_id); end
        irq_ack = 1'b1; tick(); irq_ack = 1'b0;
        tick(); tick();
        vectors++; if (irq_out !== 1'b0 || irq_pending !== 4'b0000) begin miscompares++; $display("FAIL prio_drained got out=%b pend=%b want out=0 pend=0000", irq_out, irq_pending); end
        irq_sources = '0;
        tick();
    endtask

    task automatic test_level();
        irq_mode = 4'b1101; irq_mask = 4'b0010; irq_sources = 4'b0010;
        tick();
        vectors++; if (irq_pending !== 4'b0010) begin miscompares++; $display("FAIL lvl_pend got %b want 0010", irq_pending); end
        tick();
        vectors++; if (irq_out !== 1'b1 || active_id !== 3'd1) begin miscompares++; $display("FAIL lvl_assert got out=%b id=%0d want out=1 id=1", irq_out, active_id); end
        irq_ack = 1'b1; tick(); irq_ack = 1'b0;
        vectors++; if (irq_out !== 1'b0 || irq_pending !== 4'b0010) begin miscompares++; $display("FAIL lvl_ack got out=%b pend=%b want out=0 pend=0010", irq_out, irq_pending); end
        tick();
        vectors++; if (irq_out !== 1'b0) begin miscompares++; $display("FAIL lvl_gap got %b want 0", irq_out); end
        tick();
        vectors++; if (irq_out !== 1'b1 || active_id !== 3'd1) begin miscompares++; $display("FAIL lvl_reassert got out=%b id=%0d want out=1 id=1", irq_out, active_id); end
        irq_sources = '0; tick();
        vectors++; if (irq_out !== 1'b1) begin miscompares++; $display("FAIL lvl_drop1 got %b want 1", irq_out); end
        tick();
        vectors++; if (irq_out !== 1'b0 || active_id !== 3'd7) begin miscompares++; $display("FAIL lvl_drop2 got out=%b id=%0d want out=0 id=7", irq_out, active_id); end
        irq_mode = 4'b1111;
        tick();
    endtask

    task automatic test_withdraw();
        irq_mask = 4'b0001; irq_sources = 4'b0001;
        tick(); tick();
        vectors++; if (irq_out !== 1'b1 || active_id !== 3'd0) begin miscompares++; $display("FAIL wd_assert got out=%b id=%0d want out=1 id=0", irq_out, active_id); end
        irq_mask = 4'b0000; tick();
        vectors++; if (irq_out !== 1'b1) begin miscompares++; $display("FAIL wd_delay got %b want 1", irq_out); end
        tick();
        vectors++; if (irq_out !== 1'b0 || active_id !== 3'd7 || irq_pending !== 4'b0001) begin miscompares++; $display("FAIL wd_drop got out=%b id=%0d pend=%b want out=0 id=7 pend=0001", irq_out, active_id, irq_pending); end
        pend_clr = 4'b0001; tick(); pend_clr = '0;
        vectors++; if (irq_pending !== 4'b0000) begin miscompares++; $display("FAIL wd_clr got %b want 0000", irq_pending); end
        irq_sources = '0;
        tick();
    endtask

    task automatic test_simultaneous();
        irq_mask = 4'b0000;
        irq_sources = 4'b1000; pend_clr = 4'b1000; tick();
        vectors++; if (irq_pending !== 4'b1000) begin miscompares++; $display("FAIL sim_set_beats_clr got %b want 1000", irq_pending); end
        tick();
        vectors++; if (irq_pending !== 4'b0000) begin miscompares++; $display("FAIL sim_clr got %b want 0000", irq_pending); end
        pend_clr = '0;
        irq_sources = 4'b0100; irq_mask = 4'b0100; tick(); tick();
        vectors++; if (irq_out !== 1'b1 || active_id !== 3'd2) begin miscompares++; $display("FAIL sim_assert got out=%b id=%0d want out=1 id=2", irq_out, active_id); end
        irq_mask = 4'b0000; tick();
        irq_ack = 1'b1; tick(); irq_ack = 1'b0;
        vectors++; if (irq_out !== 1'b0 || irq_pending !== 4'b0000) begin miscompares++; $display("FAIL sim_ack_wins got out=%b pend=%b want out=0 pend=0000", irq_out, irq_pending); end
        irq_sources = 4'b0001; tick(); tick();
        irq_ack = 1'b1; tick(); irq_ack = 1'b0;
        vectors++; if (irq_out !== 1'b0 || active_id !== 3'd7 || irq_pending !== 4'b0001) begin miscompares++; $display("FAIL sim_idle_ack got out=%b id=%0d pend=%b want out=0 id=7 pend=0001", irq_out, active_id, irq_pending); end
    endtask

    task automatic test_reset_mid();
        irq_mask = 4'b0001; tick(); tick();
        vectors++; if (irq_out !== 1'b1 || active_id !== 3'd0) begin miscompares++; $display("FAIL rmid_assert got out=%b id=%0d want out=1 id=0", irq_out, active_id); end
        rst = 1'b1; tick();
        vectors++; if (irq_out !== 1'b0 || active_id !== 3'd7 || irq_pending !== 4'b0000) begin miscompares++; $display("FAIL rmid_reset got out=%b id=%0d pend=%b want out=0 id=7 pend=0000", irq_out, active_id, irq_pending); end
        rst = 1'b0; tick();
        vectors++; if (irq_pending !== 4'b0001 || irq_out !== 1'b0) begin miscompares++; $display("FAIL rmid_edge got pend=%b out=%b want pend=0001 out=0", irq_pending, irq_out); end
        tick();
        vectors++; if (irq_out !== 1'b1 || active_id !== 3'd0) begin miscompares++; $display("FAIL rmid_reassert got out=%b id=%0d want out=1 id=0", irq_out, active_id); end
        irq_ack = 1'b1; tick(); irq_ack = 1'b0;
        tick(); tick(); tick();
        vectors++; if (irq_out !== 1'b0 || irq_pending !== 4'b0000) begin miscompares++; $display("FAIL rmid_single_edge got out=%b pend=%b want out=0 pend=0000", irq_out, irq_pending); end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_edge_basic();
        test_priority();
        test_level();
        test_withdraw();
        test_simultaneous();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
